seg7_scan4: RTL and testbench



---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_hex_decode.sv | 20 ++
 rtl/seg7_scan4.sv | 116 +++++++++++
 tb/tb_seg7_scan4.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, the active-high hex segment table and digit-enable helper for seg7_scan4.
`timescale 1ns/1ps
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    // Segment order {g,f,e,d,c,b,a}, active-high, nibble values 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [3:0] onehot4(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with optional blanking and common-anode inversion.
`timescale 1ns/1ps
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter int COMMON_ANODE = 0
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? 7'h00 : SEG_HEX[nibble];
        if (COMMON_ANODE != 0) begin
            seg = ~seg;
        end
    end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment scan driver with per-frame snapshot and sticky overflow DP.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
`timescale 1ns/1ps
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [15:0] Din,
    input  logic        RCO,
    input  logic        Freeze,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        Frame
);

    localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]     AN_OFF   = (COMMON_ANODE != 0) ? 4'hF : 4'h0;
    localparam logic [6:0]     SEG_OFF  = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
    localparam logic           DP_OFF   = (COMMON_ANODE != 0);

    logic [PW-1:0] pcnt_q, pcnt_d;
    digit_idx_t    dig_q, dig_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          shadow_ovf_q, shadow_ovf_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          tick, wrap, snap, guard, lz_blank;
    logic [3:0]    nib;

    assign tick = (pcnt_q == PCNT_MAX);
    assign wrap = tick && (dig_q == 2'd3);
    assign snap = wrap && !Freeze;

    always_comb begin
        pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
        dig_d        = tick ? dig_q + 2'd1 : dig_q;
        shadow_d     = snap ? Din : shadow_q;
        shadow_ovf_d = snap ? (ovf_q | RCO) : shadow_ovf_q;
        ovf_d        = snap ? 1'b0 : (ovf_q | RCO);
        frame_d      = wrap;
    end

    // Display outputs are derived from next-state values so they line up with the registered state.
    assign guard = (pcnt_d == '0);
    assign nib   = shadow_d[{dig_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (dig_d)
            2'd3:    lz_blank = (shadow_d[15:12] == 4'h0);
            2'd2:    lz_blank = (shadow_d[15:8] == 8'h00);
            2'd1:    lz_blank = (shadow_d[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg7_hex_decode #(
        .COMMON_ANODE(COMMON_ANODE)
    ) u_decode (
        .nibble(nib),
        .blank (guard | lz_blank),
        .seg   (seg_d)
    );

    always_comb begin
        an_d = guard ? AN_OFF : (onehot4(dig_d) ^ AN_OFF);
        dp_d = DP_OFF;
        if (!guard && (dig_d == 2'd3)) begin
            dp_d = shadow_ovf_d ^ DP_OFF;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pcnt_q       <= '0;
            dig_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            shadow_ovf_q <= 1'b0;
            ovf_q        <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_q      <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            dig_q        <= dig_d;
            shadow_q     <= shadow_d;
            shadow_ovf_q <= shadow_ovf_d;
            ovf_q        <= ovf_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign AN    = an_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Scoreboard bench for seg7_scan4: a common-cathode and a common-anode instance share all inputs.
`timescale 1ns/1ps
module tb_seg7_scan4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] Din = 16'h0000;
    logic        RCO = 1'b0;
    logic        Freeze = 1'b0;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fr0, fr1;
    logic [3:0]  an0, an1;

    seg7_scan4 #(.SCAN_DIV(4), .COMMON_ANODE(0)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .Din(Din), .RCO(RCO), .Freeze(Freeze),
        .SEG(seg0), .DP(dp0), .AN(an0), .Frame(fr0)
    );

    seg7_scan4 #(.SCAN_DIV(4), .COMMON_ANODE(1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .Din(Din), .RCO(RCO), .Freeze(Freeze),
        .SEG(seg1), .DP(dp1), .AN(an1), .Frame(fr1)
    );

    always #5 CLK = ~CLK;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
        bit         guard;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   tcyc = 0;
    int   rel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge CLK) tcyc <= tcyc + 1;

    task automatic push(input int c, input logic [3:0] an, input logic [6:0] seg,
                        input logic dp, input logic fr, input bit guard, input string nm);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.fr = fr; e.guard = guard; e.nm = nm;
        sb.push_back(e);
    endtask

    // Frame n of the current run: guard cycle then three lit cycles per digit slot.
    task automatic push_frame(input int n, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic dp3,
                              input string nm);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = rel + 16 * n + 4 * k;
            push(g, 4'h0, 7'h00, 1'b0, (k == 0) && (n > 0), 1'b1, nm);
            for (int j = 1; j < 4; j++)
                push(g + j, 4'b0001 << k, s[k], (k == 3) ? dp3 : 1'b0, 1'b0, 1'b0, nm);
        end
    endtask

    task automatic check(input exp_t e, input int which, input logic [3:0] an,
                         input logic [6:0] seg, input logic dp, input logic fr);
        logic [3:0] wa;
        logic [6:0] ws;
        logic       wd;
        bit         ok;
        wa = (which != 0) ? ~e.an : e.an;
        ws = (which != 0) ? ~e.seg : e.seg;
        wd = (which != 0) ? ~e.dp : e.dp;
        ok = (an === wa) && (fr === e.fr) && (e.guard || ((seg === ws) && (dp === wd)));
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d dut%0d: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b%s",
                     e.nm, e.cyc - rel, which, an, seg, dp, fr, wa, ws, wd, e.fr,
                     e.guard ? " (seg/dp not checked)" : "");
        end
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= tcyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < tcyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         e.nm, e.cyc, tcyc);
            end else begin
                check(e, 0, an0, seg0, dp0, fr0);
                check(e, 1, an1, seg1, dp1, fr1);
            end
        end
    end

    // Called just after a rising edge; reset takes effect asynchronously and is checked before the next edge.
    task automatic do_reset(input logic [15:0] din_rst);
        int t0;
        nRST = 1'b0; Din = din_rst; RCO = 1'b0; Freeze = 1'b0;
        t0 = tcyc;
        push(t0,     4'h0, 7'h00, 1'b0, 1'b0, 1'b0, "reset_async");
        push(t0 + 1, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0, "reset_hold");
        push(t0 + 2, 4'h0, 7'h00, 1'b0, 1'b0, 1'b0, "reset_hold");
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        rel = tcyc;
    endtask

    task automatic wait_rel(input int c);
        while (tcyc < rel + c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (sb.size() > 0 && n < lim) begin
            @(posedge CLK);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left after %0d cycles, want 0", sb.size(), lim);
            sb.delete();
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;

        // Reset values, first frame of zeros, then snapshot of A5C3
        do_reset(16'h1234);
        Din = 16'hA5C3;
        push_frame(0, 7'h3F, LZ, LZ, LZ, 1'b0, "first_frame");
        push_frame(1, 7'h4F, 7'h39, 7'h6D, 7'h77, 1'b0, "snap_a5c3");
        drain(100);

        // Overflow: mid-frame RCO pulse, then RCO on the wrap-tick edge
        do_reset(16'h1234);
        push_frame(0, 7'h3F, LZ, LZ, LZ, 1'b0, "ovf_f0");
        push_frame(1, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1, "ovf_mid_set");
        push_frame(2, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, "ovf_mid_clr");
        push_frame(3, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1, "ovf_wrap_set");
        push_frame(4, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, "ovf_wrap_clr");
        wait_rel(5);  RCO = 1'b1;
        wait_rel(6);  RCO = 1'b0;
        wait_rel(47); RCO = 1'b1;
        wait_rel(48); RCO = 1'b0;
        drain(100);

        // Freeze: glitch away from wrap is ignored; held across a wrap it keeps 1234 while ovf accumulates
        do_reset(16'h1234);
        push_frame(1, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, "frz_pre");
        push_frame(2, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0, "frz_hold");
        push_frame(3, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b1, "frz_release");
        wait_rel(5);  Freeze = 1'b1;
        wait_rel(10); Freeze = 1'b0;
        wait_rel(20); Freeze = 1'b1; Din = 16'h9999;
        wait_rel(22); RCO = 1'b1;
        wait_rel(23); RCO = 1'b0;
        wait_rel(36); Freeze = 1'b0;
        drain(100);

        // Leading zeros, with overflow DP on digit 3
        do_reset(16'h0000);
        Din = 16'h0070;
        push_frame(1, 7'h3F, 7'h07, LZ, LZ, 1'b1, "lead_zero");
        wait_rel(5); RCO = 1'b1;
        wait_rel(6); RCO = 1'b0;
        drain(100);

        // Reset asserted during the digit-2 slot, then a clean restart
        do_reset(16'hA5C3);
        push(rel + 16, 4'h0, 7'h00, 1'b0, 1'b1, 1'b1, "mid_g0");
        for (int j = 1; j < 4; j++) push(rel + 16 + j, 4'b0001, 7'h4F, 1'b0, 1'b0, 1'b0, "mid_d0");
        push(rel + 20, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1, "mid_g1");
        for (int j = 1; j < 4; j++) push(rel + 20 + j, 4'b0010, 7'h39, 1'b0, 1'b0, 1'b0, "mid_d1");
        push(rel + 24, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1, "mid_g2");
        push(rel + 25, 4'b0100, 7'h6D, 1'b0, 1'b0, 1'b0, "mid_d2");
        wait_rel(26);
        do_reset(16'h0000);
        push(rel, 4'h0, 7'h00, 1'b0, 1'b0, 1'b1, "restart_g0");
        for (int j = 1; j < 4; j++) push(rel + j, 4'b0001, 7'h3F, 1'b0, 1'b0, 1'b0, "restart_d0");
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
